// File: rtl/inv_shift_sub.sv
// inv_shift_sub: two-stage AES InvShiftRows -> InvSubBytes pipeline with valid/ready handshakes.
// Stage 1 registers the row-shifted state; stage 2 (data_out) registers the S-box substituted state.
// Optional macro SHIFT_SUB_DUAL_DIR_EN adds a per-transaction dir input
// (1 = inverse path, 0 = forward ShiftRows + SubBytes).
module inv_shift_sub (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
`ifdef SHIFT_SUB_DUAL_DIR_EN
    input  logic         dir,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    // FIPS-197 inverse S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

`ifdef SHIFT_SUB_DUAL_DIR_EN
    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] FwdSbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
`endif

    // Row r of column c takes the byte from column (c + off*r) mod 4; off=3 is a right rotate.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input int off);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c + off*r) % 4)+r) -: 8];
            end
        end
        return o;
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [127:0] s1_data_q, s1_data_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] data_out_q, data_out_d;
    logic [127:0] shifted;
    logic [127:0] subbed;
    logic         s1_adv, s2_adv, in_xfer;
`ifdef SHIFT_SUB_DUAL_DIR_EN
    logic         s1_dir_q, s1_dir_d;
`endif

    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    // Flush blocks acceptance so nothing lands in a stage being cleared.
    assign in_ready  = rst_n && s1_adv && !flush;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = s1_valid_q || out_valid_q;

    // Stage 1 datapath: row rotation selected by direction.
    always_comb begin
        shifted = shift_rows(data_in, 3);
`ifdef SHIFT_SUB_DUAL_DIR_EN
        if (!dir) begin
            shifted = shift_rows(data_in, 1);
        end
`endif
    end

    // Stage 2 datapath: byte-wise substitution of the stage 1 state.
    always_comb begin
        subbed = '0;
        for (int b = 0; b < 16; b++) begin
            subbed[127-8*b -: 8] = InvSbox[s1_data_q[127-8*b -: 8]];
`ifdef SHIFT_SUB_DUAL_DIR_EN
            if (!s1_dir_q) begin
                subbed[127-8*b -: 8] = FwdSbox[s1_data_q[127-8*b -: 8]];
            end
`endif
        end
    end

    // Next-state: flush wins, otherwise each stage loads when the one after it can move.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
`ifdef SHIFT_SUB_DUAL_DIR_EN
        s1_dir_d    = s1_dir_q;
`endif
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    data_out_d = subbed;
                end
            end
            if (s1_adv) begin
                s1_valid_d = in_xfer;
                if (in_xfer) begin
                    s1_data_d = shifted;
`ifdef SHIFT_SUB_DUAL_DIR_EN
                    s1_dir_d  = dir;
`endif
                end
            end
        end
    end

    // Pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
`ifdef SHIFT_SUB_DUAL_DIR_EN
            s1_dir_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
`ifdef SHIFT_SUB_DUAL_DIR_EN
            s1_dir_q    <= s1_dir_d;
`endif
        end
    end

endmodule

// File: tb/tb_inv_shift_sub.sv
// Self-checking bench for inv_shift_sub: directed vector table, backpressure, streaming,
// flush and reset sequences; round-trip checks when SHIFT_SUB_DUAL_DIR_EN is defined.
module tb_inv_shift_sub;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
`ifdef SHIFT_SUB_DUAL_DIR_EN
    logic         dir;
`endif

    inv_shift_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
`ifdef SHIFT_SUB_DUAL_DIR_EN
        .dir       (dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic [127:0] in_q[$];
    logic         dir_q[$];
    logic [127:0] got_q[$];
    int           acc_cyc[$];
    int           out_cyc[$];
    int           stall_acc;
    logic         stall_rdy;
    logic         hold_seen;
    logic         hold_bad;
    logic [127:0] hold_val;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built from GF(2^8) arithmetic rather than lookup tables.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [7:0] inv_sb(input logic [7:0] x);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
        return ginv(o ^ 8'h05);
    endfunction

    function automatic logic [7:0] fwd_sb(input logic [7:0] x);
        logic [7:0] g = ginv(x);
        logic [7:0] o;
        for (int i = 0; i < 8; i++)
            o[i] = g[i] ^ g[(i+4)%8] ^ g[(i+5)%8] ^ g[(i+6)%8] ^ g[(i+7)%8];
        return o ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic d);
        logic [127:0] o;
        logic [7:0]   v;
        int           src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = d ? 4*((c - r + 4) % 4) + r : 4*((c + r) % 4) + r;
                v   = s[127-8*src -: 8];
                o[127-8*(4*c+r) -: 8] = d ? inv_sb(v) : fwd_sb(v);
            end
        end
        return o;
    endfunction

    // Runs in_q through the DUT; out_ready stays low for the first 'stall' cycles.
    task automatic run_stream(input int stall, input int budget);
        int idx = 0;
        int cyc = 0;
        got_q.delete();
        acc_cyc.delete();
        out_cyc.delete();
        stall_acc = 0;
        stall_rdy = 1'b1;
        hold_seen = 1'b0;
        hold_bad  = 1'b0;
        while ((idx < in_q.size() || got_q.size() < in_q.size()) && cyc < budget) begin
            in_valid = (idx < in_q.size());
            data_in  = '0;
            if (in_valid) data_in = in_q[idx];
`ifdef SHIFT_SUB_DUAL_DIR_EN
            dir = 1'b1;
            if (in_valid) dir = dir_q[idx];
`endif
            out_ready = (cyc >= stall);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(data_out);
                out_cyc.push_back(cyc);
            end
            if (cyc < stall) stall_acc = idx;
            if (cyc == stall - 1) stall_rdy = in_ready;
            if (out_valid && cyc < stall) begin
                if (!hold_seen) hold_val = data_out;
                else if (data_out !== hold_val) hold_bad = 1'b1;
                hold_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_in_budget", 128'(cyc < budget), 128'd1);
    endtask

    task automatic check_results(input string name, input logic chk_lat);
        check({name, "_count"}, 128'(got_q.size()), 128'(in_q.size()));
        for (int i = 0; i < in_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), got_q[i], model(in_q[i], dir_q[i]));
            if (chk_lat) check($sformatf("%s_lat%0d", name, i),
                               128'(out_cyc[i] - acc_cyc[i]), 128'd2);
        end
    endtask

    task automatic set_one(input logic [127:0] x, input logic d);
        in_q.delete();
        dir_q.delete();
        in_q.push_back(x);
        dir_q.push_back(d);
    endtask

    // Loads two states so both stages are full with out_ready held low.
    task automatic fill_two(input logic [127:0] a, input logic [127:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = a;
`ifdef SHIFT_SUB_DUAL_DIR_EN
        dir = 1'b1;
`endif
        @(posedge clk); #1;
        data_in = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("fill_busy", 128'(busy), 128'd1);
        check("fill_out_valid", 128'(out_valid), 128'd1);
        check("fill_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[5];
        logic [127:0] fwd_res;
        vecs[0] = '{"fips_c1", 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                    128'hbd6e7c3df2b5779e0b61216e8b10b689};
        vecs[1] = '{"all_63", {16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{"all_00", {16{8'h00}}, {16{8'h52}}};
        vecs[3] = '{"all_7c", {16{8'h7c}}, {16{8'h01}}};
        vecs[4] = '{"ramp", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h52f3a3383009d79ebf366afb8140a5d5};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        data_in   = '0;
        out_ready = 1'b1;
`ifdef SHIFT_SUB_DUAL_DIR_EN
        dir = 1'b1;
`endif
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Directed table: single transactions, 2-cycle latency, one-cycle valid pulse.
        for (int i = 0; i < 5; i++) begin
            set_one(vecs[i].din, 1'b1);
            run_stream(0, 20);
            check({vecs[i].name, "_count"}, 128'(got_q.size()), 128'd1);
            if (got_q.size() > 0) begin
                check(vecs[i].name, got_q[0], vecs[i].exp);
                check({vecs[i].name, "_lat"}, 128'(out_cyc[0] - acc_cyc[0]), 128'd2);
            end
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, 128'(out_valid), 128'd0);
            @(posedge clk); #1;
        end

        // Backpressure: four inputs, out_ready low for five cycles.
        in_q.delete();
        dir_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_q.push_back({$urandom, $urandom, $urandom, $urandom});
            dir_q.push_back(1'b1);
        end
        run_stream(5, 40);
        check("bp_accepts", 128'(stall_acc), 128'd2);
        check("bp_in_ready", 128'(stall_rdy), 128'd0);
        check("bp_hold_seen", 128'(hold_seen), 128'd1);
        check("bp_hold_stable", 128'(hold_bad), 128'd0);
        check_results("bp", 1'b0);

        // Full-throughput streaming of 16 random states.
        in_q.delete();
        dir_q.delete();
        for (int i = 0; i < 16; i++) begin
            in_q.push_back({$urandom, $urandom, $urandom, $urandom});
            dir_q.push_back(1'b1);
        end
        run_stream(0, 40);
        check_results("stream", 1'b1);
        check("stream_span", 128'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 128'd15);

        // Flush with both stages full.
        fill_two(128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888);
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        @(negedge clk);
        check("flush_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 128'(out_valid), 128'd0);
        check("flush_busy", 128'(busy), 128'd0);
        set_one(128'h0123456789abcdeffedcba9876543210, 1'b1);
        run_stream(0, 20);
        check_results("post_flush", 1'b1);

        // Asynchronous reset with both stages full.
        fill_two(128'h99999999aaaaaaaabbbbbbbbcccccccc, 128'hddddddddeeeeeeeeffffffff00000000);
        in_valid = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_data_out", data_out, 128'd0);
        check("arst_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_one(128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b1);
        run_stream(0, 20);
        check("post_rst_data", got_q.size() > 0 ? got_q[0] : '0,
              128'hbd6e7c3df2b5779e0b61216e8b10b689);

`ifdef SHIFT_SUB_DUAL_DIR_EN
        // Forward then inverse recovers the original state.
        set_one(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        run_stream(0, 20);
        check_results("dual_fwd", 1'b1);
        fwd_res = got_q.size() > 0 ? got_q[0] : '0;
        set_one(fwd_res, 1'b1);
        run_stream(0, 20);
        check("dual_round_trip", got_q.size() > 0 ? got_q[0] : '0,
              128'h000102030405060708090a0b0c0d0e0f);

        // Alternating directions back-to-back.
        in_q.delete();
        dir_q.delete();
        for (int i = 0; i < 8; i++) begin
            in_q.push_back({$urandom, $urandom, $urandom, $urandom});
            dir_q.push_back(i[0]);
        end
        run_stream(0, 30);
        check_results("dual_mix", 1'b1);
`else
        fwd_res = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
